// File: rtl/s_term_pkg.sv
// Shared definitions for the south-terminal loopback pipe: the control FSM
// state encoding, the delay-select width computation and the delay clamp.
// The optional zero-latency bypass is controlled by TERM_LOOPBACK_BYPASS_EN
// in the files that use these definitions.
package s_term_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Width of one channel's delay field: enough bits to hold 0..max_delay.
  function automatic int dsel_w(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Limit a requested delay to the deepest tap the delay line provides.
  function automatic int clamp_delay(input int value, input int max_delay);
    return (value > max_delay) ? max_delay : value;
  endfunction

endpackage

// File: rtl/term_delay_line.sv
// Fixed-depth shift register for one terminal channel with a runtime tap
// select and a synchronous flush. Tap value d returns the input delayed by
// d cycles. With TERM_LOOPBACK_BYPASS_EN defined, tap 0 returns the input
// combinationally; otherwise tap 0 behaves as tap 1.
module term_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the samples along every cycle; flush wipes all stages at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // Tap mux: stage i holds the input from i+1 cycles ago.
  always_comb begin
    dout = stage[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(sel) == i + 1) dout = stage[i];
    end
`ifdef TERM_LOOPBACK_BYPASS_EN
    if (sel == '0) dout = din;
`endif
  end

endmodule

// File: rtl/s_term_loopback_pipe.sv
// South-to-north terminal loopback with a per-channel programmable delay.
// Delays are loaded through a serial shadow chain (LSB of channel 0 first)
// and applied atomically on cfg_commit, after which every delay line is
// flushed for MAX_DELAY cycles so no stale data leaks under the new timing.
// Optional feature macro: TERM_LOOPBACK_BYPASS_EN (delay 0 = combinational
// pass-through; without it, delay 0 is promoted to 1).
//
// Control handshake: cfg_en qualifies cfg_bit for one shift per cycle;
// cfg_commit is a one-cycle request honoured only in SHIFT with a full
// chain, and loses to cfg_en when both are high in the same cycle.
module s_term_loopback_pipe
  import s_term_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int NUM_SHARES = 2,
  parameter int MAX_DELAY  = 4,
  parameter int RST_DELAY  = 1
) (
  input  logic                         UserCLK,
  input  logic                         rst_n,
  input  logic [NUM_CH*NUM_SHARES-1:0] from_s,
  output logic [NUM_CH*NUM_SHARES-1:0] to_n,
  input  logic                         cfg_en,
  input  logic                         cfg_bit,
  input  logic                         cfg_commit,
  output logic                         busy,
  output logic                         cfg_err,
  output logic [1:0]                   fsm_state
);

  localparam int DSEL_W = dsel_w(MAX_DELAY);
  localparam int TOT    = NUM_CH * DSEL_W;
  localparam int CNT_W  = $clog2(TOT + 1);
  localparam int FL_W   = $clog2(MAX_DELAY + 1);
`ifdef TERM_LOOPBACK_BYPASS_EN
  localparam int RST_EFF = clamp_delay(RST_DELAY, MAX_DELAY);
`else
  localparam int RST_EFF = (clamp_delay(RST_DELAY, MAX_DELAY) < 1) ? 1
                           : clamp_delay(RST_DELAY, MAX_DELAY);
`endif

  state_t                       state;
  logic [TOT-1:0]               shadow;
  logic [CNT_W-1:0]             bit_cnt;
  logic [FL_W-1:0]              flush_cnt;
  logic [DSEL_W-1:0]            act_dly [NUM_CH];
  logic [DSEL_W-1:0]            new_dly [NUM_CH];
  logic [NUM_CH*NUM_SHARES-1:0] line_out;
  logic                         flushing;

  assign fsm_state = state;
  assign flushing  = (state == ST_FLUSH);

  // Decode the shadow chain into legal per-channel delays for a commit.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      new_dly[ch] = DSEL_W'(clamp_delay(int'(shadow[ch*DSEL_W +: DSEL_W]), MAX_DELAY));
`ifndef TERM_LOOPBACK_BYPASS_EN
      if (new_dly[ch] == '0) new_dly[ch] = DSEL_W'(1);
`endif
    end
  end

  // Configuration FSM: serial load, commit check, fixed-length flush.
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      shadow    <= '0;
      bit_cnt   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) act_dly[ch] <= DSEL_W'(RST_EFF);
    end else begin
      case (state)
        ST_RUN, ST_SHIFT: begin
          if (cfg_en) begin
            // Newest bit enters at the top; after TOT shifts the first bit
            // sent sits at bit 0. Older bits fall off the bottom.
            shadow <= (shadow >> 1) | (TOT'(cfg_bit) << (TOT - 1));
            if (bit_cnt != CNT_W'(TOT)) bit_cnt <= bit_cnt + CNT_W'(1);
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end else if ((state == ST_SHIFT) && cfg_commit) begin
            if (bit_cnt == CNT_W'(TOT)) begin
              act_dly   <= new_dly;
              state     <= ST_FLUSH;
              busy      <= 1'b1;
              flush_cnt <= '0;
            end else begin
              cfg_err <= 1'b1;
              state   <= ST_RUN;
              busy    <= 1'b0;
            end
            shadow  <= '0;
            bit_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FL_W'(MAX_DELAY - 1)) begin
            state     <= ST_RUN;
            busy      <= 1'b0;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One delay line per channel, all shares of the channel move together.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    term_delay_line #(
      .WIDTH (NUM_SHARES),
      .DEPTH (MAX_DELAY),
      .SEL_W (DSEL_W)
    ) u_line (
      .clk   (UserCLK),
      .rst_n (rst_n),
      .flush (flushing),
      .din   (from_s[ch*NUM_SHARES +: NUM_SHARES]),
      .sel   (act_dly[ch]),
      .dout  (line_out[ch*NUM_SHARES +: NUM_SHARES])
    );
  end

  assign to_n = flushing ? '0 : line_out;

endmodule

// File: doc/s_term_loopback_pipe.md
S_TERM_LOOPBACK_PIPE -- requirements
Module: s_term_loopback_pipe

Interface
REQ-001 Parameter NUM_CH, default 8, number of terminal wire channels looped from south inputs to north outputs.
REQ-002 Parameter NUM_SHARES, default 2, number of shares per channel; all shares of a channel are delayed identically.
REQ-003 Parameter MAX_DELAY, default 4, maximum per-channel delay in clock cycles; DSEL_W = clog2(MAX_DELAY+1).
REQ-004 Parameter RST_DELAY, default 1, per-channel delay value loaded at reset.
REQ-005 UserCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 from_s  input  NUM_CH*NUM_SHARES  south terminal data; bit index = ch*NUM_SHARES + share.
REQ-008 to_n  output  NUM_CH*NUM_SHARES  north terminal data; same indexing as from_s.
REQ-009 cfg_en  input  1  when high, cfg_bit is shifted into the shadow chain this cycle.
REQ-010 cfg_bit  input  1  serial configuration bit, LSB of channel 0 first.
REQ-011 cfg_commit  input  1  single-cycle request to apply the shadow chain.
REQ-012 busy  output  1  high during SHIFT and FLUSH states.
REQ-013 cfg_err  output  1  sticky error flag, cleared only by reset.

Function
REQ-014 FSM states RUN, SHIFT, FLUSH; reset state RUN.
REQ-015 RUN -> SHIFT on cfg_en; SHIFT stays on cfg_en; SHIFT -> FLUSH on cfg_commit when bit count == NUM_CH*DSEL_W; FLUSH -> RUN after exactly MAX_DELAY cycles.
REQ-016 cfg_commit in SHIFT with bit count != NUM_CH*DSEL_W: commit ignored, cfg_err set, shadow and count cleared, return to RUN.
REQ-017 cfg_commit in RUN or FLUSH: ignored, no error; cfg_en in FLUSH: ignored.
REQ-018 cfg_en and cfg_commit in the same cycle: shift takes effect, commit is ignored.
REQ-019 Bit counter saturates at NUM_CH*DSEL_W; extra bits keep shifting (oldest discarded), count stays saturated.
REQ-020 On valid commit, the active delay register takes the shadow value atomically in one cycle; a channel value above MAX_DELAY is clamped to MAX_DELAY.
REQ-021 During FLUSH all delay-line stages are cleared and to_n is all-zero.
REQ-022 In RUN, to_n[ch] equals from_s[ch] delayed by exactly the channel's active delay d cycles (1 <= d <= MAX_DELAY).
REQ-023 Data path keeps flowing during SHIFT using the previous active delays.

Reset
REQ-024 rst_n low asynchronously clears all delay stages, shadow chain, bit count, cfg_err, and forces to_n = 0, busy = 0, FSM = RUN.
REQ-025 Active delays reset to RST_DELAY per channel; reset mid-SHIFT or mid-FLUSH discards the pending configuration.

Configuration
REQ-026 Macro TERM_LOOPBACK_BYPASS_EN: when defined, active delay 0 is legal and gives combinational to_n[ch] = from_s[ch] (zero latency).
REQ-027 Without TERM_LOOPBACK_BYPASS_EN, a delay value 0 is treated as 1 and no combinational path from from_s to to_n exists.

Structure
REQ-028 Shared package s_term_pkg holds the FSM state enum, the DSEL_W computation function, and the clamp function.
REQ-029 One sub-module term_delay_line (NUM_SHARES wide, MAX_DELAY deep, runtime tap select, synchronous flush), instantiated NUM_CH times.

Verification
REQ-030 Reset: rst_n low -> to_n = 0, busy = 0, cfg_err = 0; after release, channel 0 toggling 1/0 appears on to_n after 1 cycle.
REQ-031 Valid load: NUM_CH=8, DSEL_W=3, shift 24 bits setting ch3 = 4, commit -> busy high for 4 cycles, to_n = 0, then ch3 pulse emerges 4 cycles later.
REQ-032 Short load: 10 bits then commit -> cfg_err = 1, delays unchanged, FSM back in RUN.
REQ-033 Clamp: write value 7 with MAX_DELAY=4 -> measured latency 4.
REQ-034 Bypass: with macro, ch0 = 0 -> to_n[0] follows from_s[0] in the same cycle; without macro -> latency 1.
REQ-035 Reset asserted in FLUSH -> immediate zero outputs, delays back to RST_DELAY, FSM = RUN.
